// File: rtl/fc_stream_mac.sv
// fc_stream_mac
//
// Streaming fully-connected layer for the SimpleCNN classifier back-end.
// Accepts one flattened activation per beat together with that element's
// weight for every output neuron. It keeps N_OUT signed accumulators running
// in parallel and presents the final class scores through a valid/ready
// handshake.
//
// Optional feature macro: FC_BIAS_EN
//   When defined, a bias port is added. On start each accumulator is
//   initialised to its sign-extended bias instead of zero.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (aborts any inference)
//   start      one-cycle request to begin an inference, honoured in IDLE only
//   in_valid   in_data / w_data carry a beat
//   in_ready   block accepts the current beat (ACCUM with elements outstanding)
//   in_data    signed activation, IN_W bits
//   w_data     signed weights, neuron n at [n*W_W +: W_W]
//   bias       (FC_BIAS_EN only) signed biases, neuron n at [n*W_W +: W_W]
//   out_valid  prob holds a completed result (HOLD state)
//   out_ready  consumer accepts the result
//   prob       signed scores, neuron n at [n*ACC_W +: ACC_W]
//   busy       registered, high in every state except IDLE
module fc_stream_mac #(
   parameter int IN_W  = 69,
   parameter int W_W   = 32,
   parameter int N_IN  = 1152,
   parameter int N_OUT = 10,
   parameter int ACC_W = 113
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [IN_W-1:0]        in_data,
   input  logic [N_OUT*W_W-1:0]   w_data,
`ifdef FC_BIAS_EN
   input  logic [N_OUT*W_W-1:0]   bias,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N_OUT*ACC_W-1:0] prob,
   output logic                   busy
);

   localparam int PW    = IN_W + W_W;
   localparam int CNT_W = $clog2(N_IN + 1);
   localparam logic [CNT_W-1:0] N_IN_C = CNT_W'(N_IN);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(N_IN - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   // Full-precision signed product; both operands are widened first so the
   // multiply is carried out at the full product width.
   function automatic logic signed [PW-1:0] mul_full(
      input logic signed [IN_W-1:0] a,
      input logic signed [W_W-1:0]  b
   );
      logic signed [PW-1:0] ea;
      logic signed [PW-1:0] eb;
      ea = PW'(a);
      eb = PW'(b);
      return ea * eb;
   endfunction

   // Sign-extend a product into the accumulator width.
   function automatic logic signed [ACC_W-1:0] sext_prod(
      input logic signed [PW-1:0] p
   );
      return ACC_W'(p);
   endfunction

`ifdef FC_BIAS_EN
   function automatic logic signed [ACC_W-1:0] sext_bias(
      input logic signed [W_W-1:0] b
   );
      return ACC_W'(b);
   endfunction
`endif

   logic [1:0]       state;
   logic [1:0]       state_nx;
   logic [CNT_W-1:0] cnt;
   logic             drain_cnt;
   logic             launch;
   logic             accept;

   logic                    vld_p1;
   logic signed [PW-1:0]    prod_p1 [N_OUT];
   logic signed [ACC_W-1:0] acc_p2  [N_OUT];

   assign launch    = (state == S_IDLE) && start;
   assign in_ready  = (state == S_ACCUM) && (cnt < N_IN_C);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == S_HOLD);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_ACCUM;
         S_ACCUM: if (accept && (cnt == LAST_C)) state_nx = S_DRAIN;
         // Two cycles: one for the product register, one for the accumulate.
         S_DRAIN: if (drain_cnt) state_nx = S_HOLD;
         S_HOLD:  if (out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         cnt       <= '0;
         drain_cnt <= 1'b0;
         vld_p1    <= 1'b0;
      end else begin
         state     <= state_nx;
         busy      <= (state_nx != S_IDLE);
         drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
         vld_p1    <= accept;
         if (launch)
            cnt <= '0;
         else if (accept)
            cnt <= cnt + CNT_W'(1);
      end
   end

   // ---- stage 1: per-neuron products ----
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int n = 0; n < N_OUT; n++)
            prod_p1[n] <= mul_full($signed(in_data), $signed(w_data[n*W_W +: W_W]));
      end
   end

   // ---- stage 2: accumulate (wraps modulo 2^ACC_W) ----
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < N_OUT; n++)
            acc_p2[n] <= '0;
      end else if (launch) begin
         for (int n = 0; n < N_OUT; n++)
`ifdef FC_BIAS_EN
            acc_p2[n] <= sext_bias($signed(bias[n*W_W +: W_W]));
`else
            acc_p2[n] <= '0;
`endif
      end else if (vld_p1) begin
         for (int n = 0; n < N_OUT; n++)
            acc_p2[n] <= acc_p2[n] + sext_prod(prod_p1[n]);
      end
   end

   // Accumulators are only written in ACCUM/DRAIN, so they are stable in HOLD.
   for (genvar g = 0; g < N_OUT; g++) begin : g_prob
      assign prob[g*ACC_W +: ACC_W] = acc_p2[g];
   end

endmodule

// File: tb/tb_fc_stream_mac.sv
module tb_fc_stream_mac;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic [15:0] w_data;
   logic        out_ready;
`ifdef FC_BIAS_EN
   logic [15:0] bias;
`endif

   logic        rdy_a, ov_a, busy_a;
   logic [39:0] prob_a;
   logic        rdy_b, ov_b, busy_b;
   logic [31:0] prob_b;

   int checks = 0;
   int errors = 0;

   // stimulus / reference data
   int d [4];
   int wt [2][4];
   int bias_v [2];
   logic [19:0] e20 [2];
   logic [15:0] e16 [2];

   always #5 clk = ~clk;

   fc_stream_mac #(.IN_W(8), .W_W(8), .N_IN(4), .N_OUT(2), .ACC_W(20)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_a),
      .in_data(in_data), .w_data(w_data),
`ifdef FC_BIAS_EN
      .bias(bias),
`endif
      .out_valid(ov_a), .out_ready(out_ready), .prob(prob_a), .busy(busy_a));

   fc_stream_mac #(.IN_W(8), .W_W(8), .N_IN(4), .N_OUT(2), .ACC_W(16)) dut_w (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_b),
      .in_data(in_data), .w_data(w_data),
`ifdef FC_BIAS_EN
      .bias(bias),
`endif
      .out_valid(ov_b), .out_ready(out_ready), .prob(prob_b), .busy(busy_b));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain dot product (plus bias), then truncated to each width.
   task automatic model();
      longint s;
      for (int n = 0; n < 2; n++) begin
         s = longint'(bias_v[n]);
         for (int k = 0; k < 4; k++)
            s += longint'(d[k]) * longint'(wt[n][k]);
         e20[n] = s[19:0];
         e16[n] = s[15:0];
      end
   endtask

   task automatic chk_prob(input string tag);
      for (int n = 0; n < 2; n++) begin
         chk({tag, "_prob20"}, 64'(prob_a[n*20 +: 20]), 64'(e20[n]));
         chk({tag, "_prob16"}, 64'(prob_b[n*16 +: 16]), 64'(e16[n]));
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_in_ready"}, 64'(rdy_a), 64'(0));
      chk({tag, "_out_valid"}, 64'(ov_a), 64'(0));
      chk({tag, "_busy"}, 64'(busy_a), 64'(0));
      chk({tag, "_busy_w"}, 64'(busy_b), 64'(0));
   endtask

   task automatic set_beat(input int k);
      in_data = 8'(d[k]);
      w_data  = {8'(wt[1][k]), 8'(wt[0][k])};
   endtask

   // bub: 0 none, 1 one bubble between beats, 2 random bubbles
   task automatic run_inf(input string tag, input int bub, input int hold,
                          input bit poke, input bit keep_valid);
      int lat;
      int nb;
      model();
`ifdef FC_BIAS_EN
      bias = {8'(bias_v[1]), 8'(bias_v[0])};
`endif
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_busy_after_start"}, 64'(busy_a), 64'(1));
      chk({tag, "_rdy_after_start"}, 64'(rdy_a), 64'(1));
      for (int k = 0; k < 4; k++) begin
         if (bub == 1 && k > 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            step();
         end else if (bub == 2) begin
            nb = int'($urandom_range(3));
            for (int i = 0; i < nb; i++) begin
               in_valid = 1'b0;
               in_data  = 8'($urandom);
               w_data   = 16'($urandom);
               step();
            end
         end
         in_valid = 1'b1;
         set_beat(k);
         if (poke && k == 2) start = 1'b1;
         chk({tag, "_rdy_beat"}, 64'(rdy_a), 64'(1));
         step();
         start = 1'b0;
      end
      if (keep_valid) begin
         in_data = 8'($urandom);
         w_data  = 16'($urandom);
      end else begin
         in_valid = 1'b0;
      end
      chk({tag, "_rdy_after_last"}, 64'(rdy_a), 64'(0));
      lat = 1;
      while (ov_a !== 1'b1 && lat < 8) begin
         step();
         lat++;
      end
      in_valid = 1'b0;
      chk({tag, "_latency"}, 64'(lat), 64'(3));
      chk({tag, "_out_valid_w"}, 64'(ov_b), 64'(1));
      chk_prob(tag);
      for (int i = 0; i < hold; i++) begin
         if (poke && i == 1) start = 1'b1;
         step();
         start = 1'b0;
         chk({tag, "_hold_valid"}, 64'(ov_a), 64'(1));
         chk_prob({tag, "_hold"});
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_valid_after_hs"}, 64'(ov_a), 64'(0));
      chk({tag, "_busy_after_hs"}, 64'(busy_a), 64'(0));
   endtask

   task automatic load_basic();
      d = '{1, 2, 3, 4};
      wt[0] = '{1, 1, 1, 1};
      wt[1] = '{2, -1, 0, 3};
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; w_data = '0;
      out_ready = 1'b0;
      bias_v = '{0, 0};
`ifdef FC_BIAS_EN
      bias = '0;
`endif
      step(); step();
      rst = 1'b0;
      step();
      chk_idle_outputs("reset");
      chk("reset_prob20", 64'(prob_a), 64'(0));
      chk("reset_prob16", 64'(prob_b), 64'(0));

      // basic
      load_basic();
      run_inf("basic", 0, 0, 1'b0, 1'b0);
      chk("basic_prob0_const", 64'(prob_a[19:0]), 64'(20'd10));
      chk("basic_prob1_const", 64'(prob_a[39:20]), 64'(20'd12));

      // negative / sign
      d = '{-128, -128, -128, -128};
      wt[0] = '{-128, -128, -128, -128};
      wt[1] = '{127, 127, 127, 127};
      run_inf("neg", 0, 0, 1'b0, 1'b0);

      // bubbles, backpressure, in_valid held after last beat
      load_basic();
      run_inf("bp", 1, 5, 1'b0, 1'b1);

      // reset in the middle of an inference
      start = 1'b1;
      step();
      start = 1'b0;
      d = '{50, 60, 70, 80};
      wt[0] = '{9, 9, 9, 9};
      wt[1] = '{-9, -9, -9, -9};
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         set_beat(k);
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle_outputs("midrst");
      chk("midrst_prob20", 64'(prob_a), 64'(0));
      load_basic();
      run_inf("after_rst", 0, 0, 1'b0, 1'b0);

      // ignored start pulses and wrap-around in the 16-bit instance
      d = '{127, 127, 127, 127};
      wt[0] = '{127, 127, 127, 127};
      wt[1] = '{127, 127, 127, 127};
      run_inf("wrap", 0, 3, 1'b1, 1'b0);
      chk("wrap_prob16_const", 64'(prob_b[15:0]), 64'(16'hFC04));

`ifdef FC_BIAS_EN
      load_basic();
      bias_v = '{5, -7};
      run_inf("bias", 0, 0, 1'b0, 1'b0);
      chk("bias_prob1_const", 64'(prob_a[39:20]), 64'(20'd5));
      bias_v = '{0, 0};
`endif

      // randomized inferences
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 4; k++) begin
            d[k]     = int'($urandom_range(255)) - 128;
            wt[0][k] = int'($urandom_range(255)) - 128;
            wt[1][k] = int'($urandom_range(255)) - 128;
         end
`ifdef FC_BIAS_EN
         bias_v[0] = int'($urandom_range(255)) - 128;
         bias_v[1] = int'($urandom_range(255)) - 128;
`endif
         run_inf("rand", 2, int'($urandom_range(3)), 1'($urandom_range(1)),
                 1'($urandom_range(1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
